// File: rtl/asrv32_console_tx.sv
// asrv32_console_tx: memory-mapped console/exit peripheral. Byte stores to TXDATA
// are queued in a FIFO and sent on a UART 8N1 line. A riscv-tests style exit word is latched.
// Latency: ack one cycle after a hit, with no wait states. The line starts its start bit the cycle after a pop.
// Backpressure: none on the bus. A TXDATA write to a full FIFO drops the byte and sets the sticky overflow flag.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   i_stb_data        one-cycle bus request pulse
//   i_wr_en           1 = write, 0 = read
//   i_data_addr       byte address; window is BASE_ADDR[31:4]
//   i_data_in         write data
//   i_wr_mask         byte-lane write enables
//   o_data_out        registered read data, valid with o_ack
//   o_ack             registered acknowledge, one cycle after a hit
//   o_uart_tx         registered serial line, idle high
//   o_exit_valid      sticky, set by the first valid exit write
//   o_exit_code       exit word bits [31:1]
//   o_overflow        sticky, set when a TX byte was dropped
module asrv32_console_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb_data,
  input  logic        i_wr_en,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_wr_mask,
  output logic [31:0] o_data_out,
  output logic        o_ack,
  output logic        o_uart_tx,
  output logic        o_exit_valid,
  output logic [30:0] o_exit_code,
  output logic        o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_EXIT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;

  // UART serialiser state
  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;

  logic       hit;
  logic [1:0] off;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       exit_wr;
  logic [7:0] cnt8;
  logic [31:0] status;
  logic       unused_addr_lsbs;

  // Registers are word-aligned, so the two low address bits take no part in decode.
  assign unused_addr_lsbs = &{1'b0, i_data_addr[1:0]};

  assign hit        = i_stb_data && (i_data_addr[31:4] == BASE_ADDR[31:4]);
  assign off        = i_data_addr[3:2];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);

  // The serialiser takes the head while it idles. A push into a full FIFO is still
  // accepted when that same cycle frees a slot.
  assign pop      = (state == IDLE) && !fifo_empty;
  assign push_req = hit && i_wr_en && (off == OFF_TXDATA) && i_wr_mask[0];
  assign push     = push_req && (!fifo_full || pop);

  assign exit_wr  = hit && i_wr_en && (off == OFF_EXIT) && (i_wr_mask == 4'b1111)
                    && i_data_in[0] && !o_exit_valid;

  assign cnt8   = 8'(count);
  assign status = {16'h0000, cnt8, 4'h0, o_overflow, (state != IDLE), fifo_full, fifo_empty};

  // Bus response, sticky flags and exit latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ack        <= 1'b0;
      o_data_out   <= '0;
      o_overflow   <= 1'b0;
      o_exit_valid <= 1'b0;
      o_exit_code  <= '0;
    end else begin
      o_ack <= hit;
      if (hit && !i_wr_en) begin
        case (off)
          OFF_STATUS: o_data_out <= status;
          OFF_EXIT:   o_data_out <= {o_exit_code, o_exit_valid};
          default:    o_data_out <= '0;
        endcase
      end else begin
        o_data_out <= '0;
      end
      if (push_req && !push) begin
        o_overflow <= 1'b1;
      end
      if (exit_wr) begin
        o_exit_valid <= 1'b1;
        o_exit_code  <= i_data_in[31:1];
      end
    end
  end

  // FIFO payload. The memory carries no reset because valid data is tracked only by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= i_data_in[7:0];
    end
  end

  // Pointers wrap modulo depth. The count is one bit wider so that it can hold "full".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // UART 8N1 serialiser. o_uart_tx is loaded one cycle ahead of each bit period, so the
  // line changes on the same edge that the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      o_uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (!fifo_empty) begin
            shreg     <= mem[rptr];
            state     <= START;
            o_uart_tx <= 1'b0;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud      <= '0;
            bitidx    <= '0;
            state     <= DATA;
            o_uart_tx <= shreg[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bitidx == 3'd7) begin
              state     <= STOP;
              o_uart_tx <= 1'b1;
            end else begin
              bitidx    <= bitidx + 3'd1;
              o_uart_tx <= shreg[bitidx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          baud      <= '0;
          o_uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
